// File: rtl/alu_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_unit
// Description : Decodes alu_op/funct3/funct7 into a registered ALU control
//               code. The code is held with a valid/ready handshake to the ALU.
//               Rejected decodes raise a one-cycle illegal pulse and bump a
//               saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_unit #(
  parameter int CNT_W = 6,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [6:0]       fuct7,
  input  logic [2:0]       fuct3,
  input  logic [2:0]       alu_op,
  output logic [CNT_W-1:0] alu_cnt,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             illegal,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state;
  logic [5:0]       dec_code;
  logic             dec_legal;
  logic [CNT_W-1:0] code_ext;

  // Requests are only taken while no code is outstanding.
  assign dec_ready = (state == IDLE);

  // Combinational decode of the instruction class and function fields.
  always_comb begin
    dec_code  = 6'd0;
    dec_legal = 1'b0;
    case (alu_op)
      3'b000: begin // branch
        dec_legal = 1'b1;
        case (fuct3)
          3'b000:  dec_code = 6'b011000;
          3'b001:  dec_code = 6'b011001;
          3'b100:  dec_code = 6'b011010;
          3'b101:  dec_code = 6'b011011;
          3'b110:  dec_code = 6'b011100;
          3'b111:  dec_code = 6'b011101;
          default: dec_legal = 1'b0;
        endcase
      end
      3'b001: begin // R-type
        if (fuct7 == 7'h00) begin
          dec_legal = 1'b1;
          case (fuct3)
            3'b000:  dec_code = 6'b000000;
            3'b001:  dec_code = 6'b000010;
            3'b010:  dec_code = 6'b000011;
            3'b011:  dec_code = 6'b000100;
            3'b100:  dec_code = 6'b000101;
            3'b101:  dec_code = 6'b000110;
            3'b110:  dec_code = 6'b100001;
            default: dec_code = 6'b100010;
          endcase
        end else if (fuct7 == 7'h20 && fuct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_code  = 6'b000001;
        end else if (fuct7 == 7'h20 && fuct3 == 3'b101) begin
          dec_legal = 1'b1;
          dec_code  = 6'b000111;
        end
      end
      3'b010: begin // I-arith: codes run 001101..010100 in funct3 order
        case (fuct3)
          3'b001: begin
            dec_legal = (fuct7 == 7'h00);
            dec_code  = 6'b001110;
          end
          3'b101: begin
            if (fuct7 == 7'h00) begin
              dec_legal = 1'b1;
              dec_code  = 6'b010010;
            end else if (fuct7 == 7'h20) begin
              dec_legal = 1'b1;
              dec_code  = 6'b100011;
            end
          end
          default: begin
            dec_legal = 1'b1;
            dec_code  = 6'b001101 + {3'b000, fuct3};
          end
        endcase
      end
      3'b011: begin // load
        dec_legal = 1'b1;
        case (fuct3)
          3'b000:  dec_code = 6'b001000;
          3'b001:  dec_code = 6'b001001;
          3'b010:  dec_code = 6'b001010;
          3'b100:  dec_code = 6'b001011;
          3'b101:  dec_code = 6'b001100;
          default: dec_legal = 1'b0;
        endcase
      end
      3'b100: begin // store
        dec_legal = 1'b1;
        case (fuct3)
          3'b000:  dec_code = 6'b010101;
          3'b001:  dec_code = 6'b010110;
          3'b010:  dec_code = 6'b010111;
          default: dec_legal = 1'b0;
        endcase
      end
      3'b101: begin // LUI
        dec_legal = 1'b1;
        dec_code  = 6'b011110;
      end
      3'b110: begin // AUIPC
        dec_legal = 1'b1;
        dec_code  = 6'b011111;
      end
      default: begin // JAL
        dec_legal = 1'b1;
        dec_code  = 6'b100000;
      end
    endcase
  end

  // Zero-extend the 6-bit code into the configured output width.
  always_comb begin
    code_ext      = '0;
    code_ext[5:0] = dec_code;
  end

  // Handshake FSM with registered code, valid, illegal pulse and error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_cnt   <= '0;
      cnt_valid <= 1'b0;
      illegal   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (dec_valid) begin
            if (dec_legal) begin
              alu_cnt   <= code_ext;
              cnt_valid <= 1'b1;
              state     <= ISSUE;
            end else begin
              illegal <= 1'b1;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
            end
          end
        end
        default: begin
          // Code is held until the ALU takes it; no bypass to a new request.
          if (cnt_ready) begin
            cnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_unit
// Description : Self-checking bench for alu_ctrl_unit. Two instances (default
//               widths and CNT_W=8/ERR_W=2) share one stimulus stream and are
//               compared against a table-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_unit;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [6:0] fuct7;
  logic [2:0] fuct3;
  logic [2:0] alu_op;
  logic       cnt_ready;

  logic       dec_ready0, cnt_valid0, illegal0;
  logic [5:0] alu_cnt0;
  logic [7:0] err_cnt0;
  logic       dec_ready1, cnt_valid1, illegal1;
  logic [7:0] alu_cnt1;
  logic [1:0] err_cnt1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_valid;
  int m_code;
  bit m_ill;
  int m_err;

  // Code lookup tables indexed by funct3; -1 marks an illegal encoding.
  int r_tab[8]  = '{0, 2, 3, 4, 5, 6, 33, 34};
  int ld_tab[8] = '{8, 9, 10, -1, 11, 12, -1, -1};
  int br_tab[8] = '{24, 25, -1, -1, 26, 27, 28, 29};

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    logic [5:0] code;
  } vec_t;

  vec_t vecs[29];

  alu_ctrl_unit u0 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready0),
    .fuct7(fuct7), .fuct3(fuct3), .alu_op(alu_op), .alu_cnt(alu_cnt0),
    .cnt_valid(cnt_valid0), .cnt_ready(cnt_ready), .illegal(illegal0),
    .err_cnt(err_cnt0)
  );

  alu_ctrl_unit #(.CNT_W(8), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready1),
    .fuct7(fuct7), .fuct3(fuct3), .alu_op(alu_op), .alu_cnt(alu_cnt1),
    .cnt_valid(cnt_valid1), .cnt_ready(cnt_ready), .illegal(illegal1),
    .err_cnt(err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_code(input logic [2:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7);
    int c;
    case (op)
      3'd0: c = br_tab[f3];
      3'd1: begin
        if (f7 == 7'h00) c = r_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) c = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) c = 7;
        else c = -1;
      end
      3'd2: begin
        if (f3 == 3'd1 && f7 != 7'h00) c = -1;
        else if (f3 == 3'd5 && f7 == 7'h20) c = 35;
        else if (f3 == 3'd5 && f7 != 7'h00) c = -1;
        else c = 13 + int'(f3);
      end
      3'd3: c = ld_tab[f3];
      3'd4: c = (f3 < 3'd3) ? 21 + int'(f3) : -1;
      3'd5: c = 30;
      3'd6: c = 31;
      default: c = 32;
    endcase
    return c;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_code = 0; m_ill = 0; m_err = 0;
  endtask

  task automatic model_update();
    int c;
    m_ill = 0;
    if (!m_valid) begin
      if (dec_valid) begin
        c = ref_code(alu_op, fuct3, fuct7);
        if (c >= 0) begin
          m_valid = 1;
          m_code  = c;
        end else begin
          m_ill = 1;
          m_err++;
        end
      end
    end else if (cnt_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("u0.dec_ready", dec_ready0, !m_valid);
    chk("u0.cnt_valid", cnt_valid0, m_valid);
    chk("u0.alu_cnt", alu_cnt0, m_code);
    chk("u0.illegal", illegal0, m_ill);
    chk("u0.err_cnt", err_cnt0, (m_err > 255) ? 255 : m_err);
    chk("u1.dec_ready", dec_ready1, !m_valid);
    chk("u1.cnt_valid", cnt_valid1, m_valid);
    chk("u1.alu_cnt", alu_cnt1, m_code);
    chk("u1.illegal", illegal1, m_ill);
    chk("u1.err_cnt", err_cnt1, (m_err > 3) ? 3 : m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  // Asynchronous reset pulse asserted mid-cycle; called at posedge+1.
  task automatic reset_pulse();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst.cnt_valid", cnt_valid0, 0);
    chk("async_rst.alu_cnt", alu_cnt0, 0);
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input bit rdy);
    dec_valid = v; alu_op = op; fuct3 = f3; fuct7 = f7; cnt_ready = rdy;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic ok,
                              input logic [5:0] code);
    return {op, f3, f7, ok, code};
  endfunction

  initial begin
    vecs[0]  = mk(3'd1, 3'd0, 7'h00, 1, 6'b000000);
    vecs[1]  = mk(3'd1, 3'd0, 7'h20, 1, 6'b000001);
    vecs[2]  = mk(3'd1, 3'd1, 7'h00, 1, 6'b000010);
    vecs[3]  = mk(3'd1, 3'd3, 7'h00, 1, 6'b000100);
    vecs[4]  = mk(3'd1, 3'd5, 7'h00, 1, 6'b000110);
    vecs[5]  = mk(3'd1, 3'd5, 7'h20, 1, 6'b000111);
    vecs[6]  = mk(3'd1, 3'd6, 7'h00, 1, 6'b100001);
    vecs[7]  = mk(3'd1, 3'd7, 7'h00, 1, 6'b100010);
    vecs[8]  = mk(3'd1, 3'd1, 7'h20, 0, 6'b000000);
    vecs[9]  = mk(3'd1, 3'd0, 7'h01, 0, 6'b000000);
    vecs[10] = mk(3'd2, 3'd0, 7'h7f, 1, 6'b001101);
    vecs[11] = mk(3'd2, 3'd1, 7'h00, 1, 6'b001110);
    vecs[12] = mk(3'd2, 3'd1, 7'h20, 0, 6'b000000);
    vecs[13] = mk(3'd2, 3'd5, 7'h00, 1, 6'b010010);
    vecs[14] = mk(3'd2, 3'd5, 7'h20, 1, 6'b100011);
    vecs[15] = mk(3'd2, 3'd5, 7'h01, 0, 6'b000000);
    vecs[16] = mk(3'd2, 3'd7, 7'h00, 1, 6'b010100);
    vecs[17] = mk(3'd3, 3'd0, 7'h00, 1, 6'b001000);
    vecs[18] = mk(3'd3, 3'd5, 7'h00, 1, 6'b001100);
    vecs[19] = mk(3'd3, 3'd3, 7'h00, 0, 6'b000000);
    vecs[20] = mk(3'd3, 3'd7, 7'h00, 0, 6'b000000);
    vecs[21] = mk(3'd4, 3'd2, 7'h00, 1, 6'b010111);
    vecs[22] = mk(3'd4, 3'd3, 7'h00, 0, 6'b000000);
    vecs[23] = mk(3'd0, 3'd0, 7'h00, 1, 6'b011000);
    vecs[24] = mk(3'd0, 3'd7, 7'h00, 1, 6'b011101);
    vecs[25] = mk(3'd0, 3'd2, 7'h00, 0, 6'b000000);
    vecs[26] = mk(3'd5, 3'd3, 7'h55, 1, 6'b011110);
    vecs[27] = mk(3'd6, 3'd0, 7'h00, 1, 6'b011111);
    vecs[28] = mk(3'd7, 3'd7, 7'h7f, 1, 6'b100000);

    // Reset before any clock edge: outputs must clear asynchronously.
    rst = 1'b0;
    drive(0, 3'd0, 3'd0, 7'h00, 0);
    model_reset();
    #2 rst = 1'b1;
    #1;
    check_model();
    @(posedge clk);
    #1;
    check_model();

    // First acceptance happens on the first edge after release.
    rst = 1'b0;
    drive(1, 3'd1, 3'd0, 7'h20, 0);
    step();
    chk("sub.alu_cnt", alu_cnt0, 1);
    chk("sub.cnt_valid", cnt_valid0, 1);
    chk("sub.dec_ready", dec_ready0, 0);
    // Hold three cycles; an illegal request meanwhile must be ignored.
    drive(1, 3'd3, 3'd7, 7'h00, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.alu_cnt", alu_cnt0, 1);
      chk("hold.cnt_valid", cnt_valid0, 1);
      chk("hold.err_cnt", err_cnt0, 0);
    end
    drive(0, 3'd0, 3'd0, 7'h00, 1);
    step();
    chk("release.cnt_valid", cnt_valid0, 0);
    chk("release.dec_ready", dec_ready0, 1);

    // Illegal after a branch issue keeps the previous code.
    reset_pulse();
    drive(1, 3'd0, 3'd0, 7'h00, 0);
    step();
    drive(0, 3'd0, 3'd0, 7'h00, 1);
    step();
    drive(1, 3'd3, 3'd7, 7'h00, 0);
    step();
    chk("ill.illegal", illegal0, 1);
    chk("ill.err_cnt", err_cnt0, 1);
    chk("ill.alu_cnt", alu_cnt0, 6'b011000);
    chk("ill.cnt_valid", cnt_valid0, 0);
    drive(0, 3'd0, 3'd0, 7'h00, 0);
    step();
    chk("ill.pulse_end", illegal0, 0);

    // Saturation of the 2-bit error counter over five illegal decodes.
    reset_pulse();
    drive(1, 3'd4, 3'd7, 7'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat.err_cnt", err_cnt1, (i < 3) ? i + 1 : 3);
      chk("sat.illegal", illegal1, 1);
    end
    drive(0, 3'd0, 3'd0, 7'h00, 0);
    step();

    // Reset during ISSUE discards the pending JAL code.
    drive(1, 3'd7, 3'd0, 7'h00, 0);
    step();
    chk("jal.cnt_valid", cnt_valid0, 1);
    drive(0, 3'd0, 3'd0, 7'h00, 0);
    reset_pulse();
    chk("jal.dec_ready", dec_ready0, 1);

    // Table of per-encoding expectations.
    for (int i = 0; i < 29; i++) begin
      drive(1, vecs[i].op, vecs[i].f3, vecs[i].f7, 0);
      step();
      if (vecs[i].ok) begin
        chk("tab.u0.alu_cnt", alu_cnt0, vecs[i].code);
        chk("tab.u1.alu_cnt", alu_cnt1, vecs[i].code);
        chk("tab.cnt_valid", cnt_valid0, 1);
      end else begin
        chk("tab.illegal", illegal0, 1);
        chk("tab.cnt_valid", cnt_valid0, 0);
      end
      drive(0, 3'd0, 3'd0, 7'h00, 1);
      step();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [6:0] f7;
      sel = int'($urandom_range(0, 3));
      f7  = (sel == 1) ? 7'h20 : (sel == 3) ? 7'($urandom_range(0, 127)) : 7'h00;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), f7, $urandom_range(0, 1) == 1);
      if (i % 200 == 150) reset_pulse();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_unit.md
ALU_CTRL_UNIT -- requirements
Module: alu_ctrl_unit

Interface
REQ-001 Parameter: CNT_W, default 6, width of alu_cnt (legal range 6..16); codes are zero-extended into the upper bits.
REQ-002 Parameter: ERR_W, default 8, width of the saturating illegal-decode counter.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: dec_valid  in  1  decode request valid.
REQ-006 Port: dec_ready  out  1  block accepts a decode request.
REQ-007 Port: fuct7  in  7  instruction funct7 field.
REQ-008 Port: fuct3  in  3  instruction funct3 field.
REQ-009 Port: alu_op  in  3  class: 000 branch, 001 R, 010 I-arith, 011 load, 100 store, 101 LUI, 110 AUIPC, 111 JAL.
REQ-010 Port: alu_cnt  out  CNT_W  registered ALU control code.
REQ-011 Port: cnt_valid  out  1  alu_cnt holds an issued code.
REQ-012 Port: cnt_ready  in  1  ALU consumes alu_cnt.
REQ-013 Port: illegal  out  1  one-cycle pulse on a rejected decode.
REQ-014 Port: err_cnt  out  ERR_W  count of rejected decodes.

Function
REQ-015 FSM states IDLE and ISSUE; dec_ready SHALL equal 1 in IDLE, 0 in ISSUE.
REQ-016 Handshake: a request is accepted on a rising edge with dec_valid=1 and dec_ready=1; the fields are sampled on that edge only.
REQ-017 Legal accept: alu_cnt loads the decoded code, cnt_valid=1, state -> ISSUE; latency 1 cycle from accept edge.
REQ-018 ISSUE: alu_cnt and cnt_valid SHALL remain stable until an edge with cnt_ready=1, then cnt_valid=0, state -> IDLE; no same-cycle bypass, so peak throughput is 1 code per 2 cycles.
REQ-019 Illegal accept: alu_cnt keeps its previous value, cnt_valid stays 0, state stays IDLE, illegal=1 for exactly one cycle, err_cnt += 1, saturating at all-ones.
REQ-020 R codes: add 000000 (f7=00), sub 000001 (f7=20), sll 000010, slt 000011, sltu 000100, xor 000101, srl 000110 (f7=00), sra 000111 (f7=20), or 100001, and 100010.
REQ-021 R legality: f7 must be 00, or 20 only with f3=000 or 101; otherwise illegal.
REQ-022 I-arith codes by f3 000..111: 001101..010100; f3=101 with f7=20 gives srai 100011.
REQ-023 I-arith legality: f3=001 requires f7=00; f3=101 requires f7=00 or 20; f7 ignored otherwise.
REQ-024 Load codes: f3=000 001000, 001 001001, 010 001010, 100 001011, 101 001100; f3=011/110/111 illegal.
REQ-025 Store codes: f3=000 010101, 001 010110, 010 010111; f3>=011 illegal.
REQ-026 Branch codes: f3=000 011000, 001 011001, 100 011010, 101 011011, 110 011100, 111 011101; f3=010/011 illegal.
REQ-027 LUI 011110, AUIPC 011111, JAL 100000; fuct7/fuct3 ignored, always legal.
REQ-028 dec_valid while dec_ready=0 SHALL be ignored (no sampling, no error count).

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, alu_cnt=0, cnt_valid=0, illegal=0, err_cnt=0, independent of clk.
REQ-030 Reset asserted during ISSUE SHALL drop cnt_valid without waiting for cnt_ready; the pending code is discarded.
REQ-031 The first acceptance after reset release SHALL occur on the first edge with rst=0 and dec_valid=1.

Verification
REQ-032 alu_op=001, f3=000, f7=20, dec_valid=1 -> next cycle alu_cnt=000001, cnt_valid=1, dec_ready=0; held for 3 cycles with cnt_ready=0; cnt_ready=1 -> cnt_valid=0, dec_ready=1.
REQ-033 After issuing 011000, alu_op=011, f3=111 -> illegal high for 1 cycle, err_cnt=1, alu_cnt stays 011000, cnt_valid=0.
REQ-034 CNT_W=8, alu_op=010, f3=101, f7=20 -> alu_cnt=00100011; f7=01 -> illegal.
REQ-035 ERR_W=2, five consecutive illegal decodes -> err_cnt 1,2,3,3,3.
REQ-036 alu_op=111 accepted, rst pulsed while cnt_valid=1 -> cnt_valid=0 and alu_cnt=0 before the next clk edge; dec_ready=1 after release.
